poly_voice_mixer: RTL and testbench

Parametrised N-voice mixer placed between the note-player voices and the codec conditioner in the music player. It replaces the fixed three-voice combinational sum-and-clip with a time-multiplexed multiply-accumulate over per-voice snapshots. It adds programmable per-voice gain, a voice enable mask, sticky clip/overrun flags and a registered, handshaken output sample.

---
 rtl/mixer_pkg.sv | 26 ++
 rtl/sample_saturate.sv | 26 ++
 rtl/poly_voice_mixer.sv | 180 ++++++++++++++++++
 tb/tb_poly_voice_mixer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and constant helpers for the poly_voice_mixer slice.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT
    } mix_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Accumulator is sized so that NUM_VOICES full-scale products can never overflow it.
    function automatic int accWidth(input int sampleW, input int gainW, input int numVoices);
        return sampleW + gainW + 1 + clog2(numVoices);
    endfunction

    function automatic int unityGain(input int gainW);
        return 1 << (gainW - 1);
    endfunction

endpackage

// File: rtl/sample_saturate.sv
// Combinational clamp of a wide signed value into an OUT_W-bit signed sample.
module sample_saturate #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value_i,
    output logic signed [OUT_W-1:0] sample_o,
    output logic                    clip_o
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        sample_o = value_i[OUT_W-1:0];
        clip_o   = 1'b0;
        if (value_i > MAX_V) begin
            sample_o = MAX_V[OUT_W-1:0];
            clip_o   = 1'b1;
        end else if (value_i < MIN_V) begin
            sample_o = MIN_V[OUT_W-1:0];
            clip_o   = 1'b1;
        end
    end

endmodule

// File: rtl/poly_voice_mixer.sv
// Time-multiplexed N-voice gain/enable mixer with saturation and sticky flags.
// Optional master fade ramp enabled by defining MIXER_FADE_EN.
module poly_voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 4,
    parameter int MIX_SHIFT  = 1,
    parameter int FADE_STEPS = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]          voice_valid,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    input  logic                           gain_we,
    input  logic [2:0]                     gain_addr,
    input  logic [GAIN_W-1:0]              gain_data,
    input  logic                           mix_req,
    input  logic                           mute,
    input  logic                           clear_flags,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           clip_flag,
    output logic                           overrun_flag
);

    localparam int ACC_W  = accWidth(SAMPLE_W, GAIN_W, NUM_VOICES);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;
    localparam int SHIFT  = GAIN_W - 1 + MIX_SHIFT;
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unityGain(GAIN_W));
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic signed [SAMPLE_W-1:0] hold_q     [NUM_VOICES];
    logic        [GAIN_W-1:0]   gain_q     [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] snap_q     [NUM_VOICES];
    logic        [GAIN_W-1:0]   snapGain_q [NUM_VOICES];
    logic [NUM_VOICES-1:0]      snapEn_q;

    mix_state_e                 state_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [SAMPLE_W-1:0] sampleOut_q;
    logic                       sampleValid_q;
    logic                       clip_q;
    logic                       overrun_q;

    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [SAMPLE_W-1:0] clamped;
    logic signed [SAMPLE_W-1:0] outSample;
    logic                       satClip;
    logic                       clipSet;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                hold_q[i] <= '0;
                gain_q[i] <= UNITY;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_valid[i]) hold_q[i] <= voice_samples[i*SAMPLE_W +: SAMPLE_W];
                if (gain_we && gain_addr == 3'(i)) gain_q[i] <= gain_data;
            end
        end
    end

    // Gain is zero-extended so the product stays a plain signed multiply.
    always_comb begin
        product = PROD_W'(snap_q[idx_q]) * PROD_W'($signed({1'b0, snapGain_q[idx_q]}));
        term    = snapEn_q[idx_q] ? ACC_W'(product) : '0;
        shifted = acc_q >>> SHIFT;
    end

    sample_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) uSat (
        .value_i  (shifted),
        .sample_o (clamped),
        .clip_o   (satClip)
    );

`ifdef MIXER_FADE_EN
    localparam int FADE_SH = clog2(FADE_STEPS);
    localparam int LVL_W   = FADE_SH + 1;
    localparam int FP_W    = SAMPLE_W + LVL_W + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_STEPS);

    logic [LVL_W-1:0]       level_q;
    logic [LVL_W-1:0]       levelNext;
    logic signed [FP_W-1:0] fadeProd;
    logic signed [FP_W-1:0] fadeShifted;
    logic                   fadeClip;

    // The level used by a mix is the one after this mix's step.
    always_comb begin
        levelNext = level_q;
        if (mute) begin
            if (level_q != '0) levelNext = level_q - LVL_W'(1);
        end else if (level_q != LVL_MAX) begin
            levelNext = level_q + LVL_W'(1);
        end
        fadeProd    = FP_W'(clamped) * FP_W'($signed({1'b0, levelNext}));
        fadeShifted = fadeProd >>> FADE_SH;
    end

    sample_saturate #(.IN_W(FP_W), .OUT_W(SAMPLE_W)) uFadeSat (
        .value_i  (fadeShifted),
        .sample_o (outSample),
        .clip_o   (fadeClip)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= LVL_MAX;
        else if (state_q == SAT) level_q <= levelNext;
    end

    // A scaled-down clamp can never exceed the range, so fadeClip is always 0.
    assign clipSet = (state_q == SAT) && (satClip || fadeClip);
`else
    assign outSample = mute ? '0 : clamped;
    assign clipSet   = (state_q == SAT) && satClip;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            snap_q        <= '{default: '0};
            snapGain_q    <= '{default: '0};
            snapEn_q      <= '0;
            sampleOut_q   <= '0;
            sampleValid_q <= 1'b0;
            clip_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sampleValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mix_req) begin
                        snap_q     <= hold_q;
                        snapGain_q <= gain_q;
                        snapEn_q   <= voice_enable;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + term;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_q <= SAT;
                end
                SAT: begin
                    sampleOut_q   <= outSample;
                    sampleValid_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Sticky flags: a set event in the same cycle beats clear_flags.
            if (clipSet) clip_q <= 1'b1;
            else if (clear_flags) clip_q <= 1'b0;
            if (mix_req && state_q != IDLE) overrun_q <= 1'b1;
            else if (clear_flags) overrun_q <= 1'b0;
        end
    end

    assign sample_out   = sampleOut_q;
    assign sample_valid = sampleValid_q;
    assign busy         = (state_q != IDLE);
    assign clip_flag    = clip_q;
    assign overrun_flag = overrun_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Self-checking bench for poly_voice_mixer: arithmetic model plus directed vectors.
module tb_poly_voice_mixer;

    localparam int NV = 3;
    localparam int SW = 16;
    localparam int GW = 4;
    localparam int MS = 1;
`ifdef MIXER_FADE_EN
    localparam int FADE = 4;
`else
    localparam int FADE = 64;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NV*SW-1:0]     voice_samples = '0;
    logic [NV-1:0]        voice_valid = '0;
    logic [NV-1:0]        voice_enable = '1;
    logic                 gain_we = 1'b0;
    logic [2:0]           gain_addr = '0;
    logic [GW-1:0]        gain_data = '0;
    logic                 mix_req = 1'b0;
    logic                 mute = 1'b0;
    logic                 clear_flags = 1'b0;
    logic signed [SW-1:0] sample_out;
    logic                 sample_valid;
    logic                 busy;
    logic                 clip_flag;
    logic                 overrun_flag;

    always #5 clk = ~clk;

    poly_voice_mixer #(
        .NUM_VOICES (NV),
        .SAMPLE_W   (SW),
        .GAIN_W     (GW),
        .MIX_SHIFT  (MS),
        .FADE_STEPS (FADE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .voice_samples (voice_samples),
        .voice_valid   (voice_valid),
        .voice_enable  (voice_enable),
        .gain_we       (gain_we),
        .gain_addr     (gain_addr),
        .gain_data     (gain_data),
        .mix_req       (mix_req),
        .mute          (mute),
        .clear_flags   (clear_flags),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .clip_flag     (clip_flag),
        .overrun_flag  (overrun_flag)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a mix accepted in cycle c is busy in c+1..c+NV+1 and presents its result in c+NV+2.
    int mHold [NV];
    int mGain [NV];
    int cyc = 0;
    int mAccept = -1;
    int mIdleFrom = 0;
    int mValidCycle = -1;
    int mRaw = 0;
    int mOut = 0;
    int mLevel = FADE;
    bit mLive = 0;
    bit mClip = 0;
    bit mOv = 0;
    int mResult, mClamped;
    bit busyNow, setOv, setClip;

    function automatic int clampSample(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                mHold[i] = 0;
                mGain[i] = 8;
            end
            mAccept = cyc;
            mIdleFrom = cyc;
            mValidCycle = -1;
            mLive = 0;
            mOut = 0;
            mClip = 0;
            mOv = 0;
            mLevel = FADE;
        end else begin
            busyNow = (cyc > mAccept) && (cyc < mIdleFrom);
            setOv = mix_req && busyNow;
            setClip = 0;
            if (mLive && cyc == mIdleFrom - 1) begin
                mResult = mRaw >>> (GW - 1 + MS);
                mClamped = clampSample(mResult);
                setClip = (mClamped != mResult);
`ifdef MIXER_FADE_EN
                if (mute) mLevel = (mLevel > 0) ? mLevel - 1 : 0;
                else mLevel = (mLevel < FADE) ? mLevel + 1 : FADE;
                mOut = (mClamped * mLevel) >>> $clog2(FADE);
`else
                mOut = mute ? 0 : mClamped;
`endif
                mValidCycle = cyc + 1;
                mLive = 0;
            end
            if (mix_req && !busyNow) begin
                mRaw = 0;
                for (int i = 0; i < NV; i++)
                    if (voice_enable[i]) mRaw += mHold[i] * mGain[i];
                mAccept = cyc;
                mIdleFrom = cyc + NV + 2;
                mLive = 1;
            end
            mOv = setOv ? 1'b1 : (clear_flags ? 1'b0 : mOv);
            mClip = setClip ? 1'b1 : (clear_flags ? 1'b0 : mClip);
            for (int i = 0; i < NV; i++) begin
                if (voice_valid[i]) mHold[i] = $signed(voice_samples[i*SW +: SW]);
                if (gain_we && gain_addr == i) mGain[i] = gain_data;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_sample", sample_out, 0);
            checkOutput("rst_valid", sample_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_clip", clip_flag, 0);
            checkOutput("rst_overrun", overrun_flag, 0);
        end else begin
            checkOutput("valid", sample_valid, mValidCycle == cyc);
            checkOutput("sample", sample_out, mOut);
            checkOutput("busy", busy, (cyc > mAccept) && (cyc < mIdleFrom));
            checkOutput("clip", clip_flag, mClip);
            checkOutput("overrun", overrun_flag, mOv);
        end
    end

    task automatic applyStimulus(input logic [NV-1:0] vv, input int s0, input int s1, input int s2,
                                 input logic gwe, input logic [2:0] ga, input logic [GW-1:0] gd,
                                 input logic clr);
        voice_valid = vv;
        voice_samples = {SW'(s2), SW'(s1), SW'(s0)};
        gain_we = gwe;
        gain_addr = ga;
        gain_data = gd;
        clear_flags = clr;
        @(posedge clk);
        #1;
        voice_valid = '0;
        gain_we = 1'b0;
        clear_flags = 1'b0;
    endtask

    // Returns at the negedge of the sample_valid cycle.
    task automatic runMix(input string name, input int expected);
        bit seen;
        seen = 0;
        mix_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            mix_req = 1'b0;
            voice_valid = '0;
            gain_we = 1'b0;
            @(negedge clk);
            if (sample_valid) begin
                checkOutput({name, "_latency"}, n, NV + 2);
                checkOutput({name, "_value"}, sample_out, expected);
                seen = 1;
                break;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    int validCount;
    int lastValue;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(3'b111, 1000, 2000, 3000, 0, 0, 0, 0);
        runMix("basic", 3000);
        runMix("back_to_back", 3000);
        checkOutput("b2b_no_overrun", overrun_flag, 0);

        applyStimulus(3'b111, 30000, 30000, 30000, 0, 0, 0, 0);
        runMix("clip_pos", 32767);
        checkOutput("clip_pos_flag", clip_flag, 1);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("clip_cleared", clip_flag, 0);
        applyStimulus(3'b111, -30000, -30000, -30000, 0, 0, 0, 0);
        runMix("clip_neg", -32768);
        checkOutput("clip_neg_flag", clip_flag, 1);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1);
        clear_flags = 1'b1;
        runMix("clip_set_wins", -32768);
        checkOutput("clip_set_wins_flag", clip_flag, 1);
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        checkOutput("clip_after_clear", clip_flag, 0);

        applyStimulus(3'b000, 0, 0, 0, 1, 3'd1, 4'd0, 0);
        applyStimulus(3'b000, 0, 0, 0, 1, 3'd5, 4'd0, 0);
        voice_enable = 3'b101;
        applyStimulus(3'b111, 100, 200, 300, 0, 0, 0, 0);
        runMix("gain0_en101", 200);
        voice_enable = 3'b111;
        applyStimulus(3'b000, 0, 0, 0, 1, 3'd2, 4'd15, 0);
        runMix("gain15", 331);
        applyStimulus(3'b000, 0, 0, 0, 1, 3'd1, 4'd8, 0);
        applyStimulus(3'b000, 0, 0, 0, 1, 3'd2, 4'd8, 0);

        applyStimulus(3'b111, -1001, 0, 0, 0, 0, 0, 0);
        runMix("neg_floor", -501);

        applyStimulus(3'b111, 100, 200, 300, 0, 0, 0, 0);
        voice_valid = 3'b001;
        voice_samples = {SW'(300), SW'(200), SW'(500)};
        runMix("coincident_old", 300);
        runMix("coincident_new", 500);

        mix_req = 1'b1;
        @(posedge clk);
        #1;
        mix_req = 1'b0;
        @(posedge clk);
        #1;
        mix_req = 1'b1;
        @(posedge clk);
        #1;
        mix_req = 1'b0;
        validCount = 0;
        lastValue = 0;
        repeat (12) begin
            @(negedge clk);
            if (sample_valid) begin
                validCount++;
                lastValue = sample_out;
            end
        end
        checkOutput("overrun_pulses", validCount, 1);
        checkOutput("overrun_value", lastValue, 500);
        checkOutput("overrun_flag", overrun_flag, 1);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("overrun_cleared", overrun_flag, 0);

        voice_enable = 3'b000;
        runMix("all_disabled", 0);
        voice_enable = 3'b111;

        applyStimulus(3'b111, 4000, 4000, 0, 0, 0, 0, 0);
        mute = 1'b1;
`ifdef MIXER_FADE_EN
        runMix("fade_down1", 3000);
        runMix("fade_down2", 2000);
        runMix("fade_down3", 1000);
        runMix("fade_down4", 0);
        runMix("fade_down5", 0);
        mute = 1'b0;
        runMix("fade_up1", 1000);
        runMix("fade_up2", 2000);
        runMix("fade_up3", 3000);
        runMix("fade_up4", 4000);
`else
        runMix("muted", 0);
        mute = 1'b0;
        runMix("unmuted", 4000);
`endif

        mix_req = 1'b1;
        @(posedge clk);
        #1;
        mix_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_sample", sample_out, 0);
        checkOutput("midreset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        validCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample_valid) validCount++;
        end
        checkOutput("midreset_no_pulse", validCount, 0);
        runMix("post_reset", 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
